lvds_pattern_gen: RTL
=====================

Name: lvds_pattern_gen

Overview:
Dual-pixel test-pattern source feeding the LVDS panel transmitter's color/color_even inputs. Consumes the transmitter's pixel coordinates and produces the 24-bit RGB for the even and odd pixel of each pair, with a fixed 2-cycle pipeline latency. Pattern selection comes from a debounced push-button and an optional auto-cycle timer; pattern changes are applied only at frame start to avoid tearing.

Parameters:
H_PAIRS, 512, active pixel pairs per line (panel width / 2)
V_ACTIVE, 600, active lines per frame
AUTO_FRAMES, 120, frames per pattern in auto mode (≥1)
DEBOUNCE_CYCLES, 500000, i_clk cycles the button must be stable
NUM_PATTERNS, 6, number of patterns; codes 0..NUM_PATTERNS-1

Ports:
i_clk  in  1  pixel clock, same domain as LVDS transmitter
i_resetn  in  1  asynchronous active-low reset
i_x  in  12  pixel-pair index from transmitter (even pixel = 2*i_x, odd = 2*i_x+1)
i_y  in  12  line index from transmitter
i_valid  in  1  strobe: i_x/i_y address a new pair this cycle
i_button  in  1  raw async push-button, active-high
i_auto  in  1  level: enable auto-cycling
o_color  out  24  RGB {R,G,B} for even pixel
o_color_even  out  24  RGB for odd pixel (transmitter's second channel)
o_valid  out  1  o_color/o_color_even correspond to i_valid 2 cycles earlier
o_pattern  out  3  currently displayed pattern code

Behaviour:
- Reset (async assert, sync-released use): o_color=0, o_color_even=0, o_valid=0, o_pattern=0, pending=0, frame counter=0, bar position=0, debouncer state=0.
- Pipeline: stage 1 registers i_x,i_y,i_valid, computes in-range flag (i_x<H_PAIRS && i_y<V_ACTIVE) and bar index; stage 2 registers both colors and o_valid. Latency exactly 2 cycles; one pair per cycle throughput; i_valid low -> o_valid low 2 cycles later, colors hold previous value.
- Out-of-range coordinates -> both colors 24'h000000 with o_valid still asserted.
- Patterns (px = pixel x, 0..2*H_PAIRS-1):
  0 solid white FFFFFF;
  1 eight vertical color bars, bar = px*8/(2*H_PAIRS), order white,yellow,cyan,green,magenta,red,blue,black;
  2 horizontal grey ramp, level = px[9:2] replicated to R,G,B (wraps at 1024 px);
  3 checkerboard 16x16 px: white if px[4]^y[4] else black;
  4 moving bar: red 16 px wide at px in [pos, pos+15], else black; pos advances 2 px per frame, wraps to 0 when pos ≥ 2*H_PAIRS;
  5 1-px white border on first/last column and row, black inside.
- Frame start = i_valid && i_x==0 && i_y==0 (stage-1 input side).
- Advance request: debounced button rising edge, or (i_auto && frame counter reaches AUTO_FRAMES-1 at frame start). Request sets pending; at next frame start pattern=pattern+1, wrap NUM_PATTERNS-1 -> 0, pending cleared. Multiple requests within one frame collapse to a single advance. Button and auto coinciding -> single advance.
- Frame counter: increments at each frame start while i_auto; resets to 0 on its terminal count, on any applied advance, and while i_auto low.
- Pattern register updates on the frame-start cycle; the frame-start pair itself already uses the new pattern.
- Debouncer: 2-FF synchronizer, counter reloads on any change of synced input, debounced level updates when counter reaches DEBOUNCE_CYCLES-1; emits one-cycle rise pulse.
- Reset mid-frame: pipeline flushes, output resumes at next valid with pattern 0.

Decomposition:
- Package lvds_pattern_pkg: pattern code constants (PAT_WHITE..PAT_BORDER), 24-bit color constants (white, yellow, cyan, green, magenta, red, blue, black), bar-lookup function.
- Sub-module lvds_btn_debounce (synchronizer + counter + rise pulse), parameter DEBOUNCE_CYCLES.

Test Plan:
- Reset, i_valid=1, x=0,y=0, pattern 0 -> two cycles later o_valid=1, both colors FFFFFF; o_pattern=0.
- Pattern 1 forced via button, x=64 (px 128,129), H_PAIRS=512 -> bar 1 both: FFFF00 / FFFF00; x=255 -> bar 3 and 3: 00FF00 both.
- Button pulse mid-frame (DEBOUNCE_CYCLES=4 in sim) -> o_pattern unchanged until next x=0,y=0 strobe, then increments by 1; two presses in one frame -> +1 only.
- i_auto=1, AUTO_FRAMES=3, pattern 5 -> after 3 frame starts pattern wraps to 0; i_auto low -> no change over 10 frames.
- Pattern 4 -> frame n red at px 2n..2n+15; with H_PAIRS=8, pos wraps to 0 after 8 frames.
- x=H_PAIRS or y=V_ACTIVE -> colors 000000, o_valid=1; i_resetn low mid-frame -> outputs 0 immediately (async), o_pattern=0.

Source files
------------

// File: rtl/lvds_pattern_pkg.sv
// Shared pattern codes, RGB constants and color-bar helpers for the LVDS test-pattern source.
package lvds_pattern_pkg;

  localparam int unsigned PAT_W   = 3;
  localparam int unsigned COLOR_W = 24;

  localparam logic [PAT_W-1:0] PAT_WHITE   = 3'd0;
  localparam logic [PAT_W-1:0] PAT_BARS    = 3'd1;
  localparam logic [PAT_W-1:0] PAT_RAMP    = 3'd2;
  localparam logic [PAT_W-1:0] PAT_CHECKER = 3'd3;
  localparam logic [PAT_W-1:0] PAT_MOVING  = 3'd4;
  localparam logic [PAT_W-1:0] PAT_BORDER  = 3'd5;

  localparam logic [COLOR_W-1:0] COLOR_WHITE   = 24'hFFFFFF;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW  = 24'hFFFF00;
  localparam logic [COLOR_W-1:0] COLOR_CYAN    = 24'h00FFFF;
  localparam logic [COLOR_W-1:0] COLOR_GREEN   = 24'h00FF00;
  localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 24'hFF00FF;
  localparam logic [COLOR_W-1:0] COLOR_RED     = 24'hFF0000;
  localparam logic [COLOR_W-1:0] COLOR_BLUE    = 24'h0000FF;
  localparam logic [COLOR_W-1:0] COLOR_BLACK   = 24'h000000;

  // Bar number 0..7 for a pixel column: px*8 / (2*h_pairs).
  function automatic logic [2:0] bar_index(input logic [12:0] px, input int unsigned h_pairs);
    return 3'((32'(px) << 2) / h_pairs);
  endfunction

  function automatic logic [COLOR_W-1:0] bar_color(input logic [2:0] bar);
    logic [COLOR_W-1:0] c;
    case (bar)
      3'd0:    c = COLOR_WHITE;
      3'd1:    c = COLOR_YELLOW;
      3'd2:    c = COLOR_CYAN;
      3'd3:    c = COLOR_GREEN;
      3'd4:    c = COLOR_MAGENTA;
      3'd5:    c = COLOR_RED;
      3'd6:    c = COLOR_BLUE;
      default: c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lvds_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and one-cycle rising-edge pulse.
module lvds_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_button,
  output logic o_rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             sync_d;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Any change of the synced input restarts the stability window.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      o_rise <= 1'b0;
    end else begin
      sync1  <= i_button;
      sync2  <= sync1;
      sync_d <= sync2;
      o_rise <= 1'b0;
      if (sync2 != sync_d) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CNT_W'(1);
      end else if (level != sync2) begin
        level  <= sync2;
        o_rise <= sync2;
      end
    end
  end

endmodule

// File: rtl/lvds_pattern_gen.sv
// Dual-pixel test-pattern source for the LVDS transmitter: 2-stage pipeline from pair
// coordinates to even/odd RGB, with pattern changes deferred to frame start.
module lvds_pattern_gen
  import lvds_pattern_pkg::*;
#(
  parameter int unsigned H_PAIRS         = 512,
  parameter int unsigned V_ACTIVE        = 600,
  parameter int unsigned AUTO_FRAMES     = 120,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned NUM_PATTERNS    = 6
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic [11:0]        i_x,
  input  logic [11:0]        i_y,
  input  logic               i_valid,
  input  logic               i_button,
  input  logic               i_auto,
  output logic [COLOR_W-1:0] o_color,
  output logic [COLOR_W-1:0] o_color_even,
  output logic               o_valid,
  output logic [PAT_W-1:0]   o_pattern
);

  localparam int unsigned CW   = 12;
  localparam int unsigned PXW  = 13;
  localparam int unsigned FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [PXW-1:0]   PX_LAST  = PXW'(2 * H_PAIRS - 1);
  localparam logic [PXW:0]     PX_SPAN  = (PXW + 1)'(2 * H_PAIRS);
  localparam logic [CW-1:0]    Y_LAST   = CW'(V_ACTIVE - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(AUTO_FRAMES - 1);

  logic             btn_rise;
  logic             pending;
  logic [FC_W-1:0]  frame_cnt;
  logic [PXW-1:0]   bar_pos;
  logic [PXW-1:0]   bar_next;
  logic [PXW:0]     bar_inc_c;
  logic [PXW-1:0]   bar_wrap_c;
  logic             frame_start_c;
  logic             advance_c;

  logic [CW-1:0]    x1;
  logic [CW-1:0]    y1;
  logic             v1;
  logic             in1;
  logic [2:0]       bar_e1;
  logic [2:0]       bar_o1;

  lvds_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .i_clk   (i_clk),
    .i_resetn(i_resetn),
    .i_button(i_button),
    .o_rise  (btn_rise)
  );

  // Frame-start decode and advance decision on the stage-1 input side.
  always_comb begin
    frame_start_c = i_valid && (i_x == '0) && (i_y == '0);
    advance_c     = frame_start_c && (pending || btn_rise || (i_auto && (frame_cnt == FC_LAST)));
    bar_inc_c     = (PXW + 1)'(bar_next) + (PXW + 1)'(2);
    bar_wrap_c    = (bar_inc_c >= PX_SPAN) ? '0 : bar_inc_c[PXW-1:0];
  end

  // bar_pos is the position shown this frame; bar_next is what the next frame will show.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_pattern <= PAT_WHITE;
      pending   <= 1'b0;
      frame_cnt <= '0;
      bar_pos   <= '0;
      bar_next  <= '0;
    end else begin
      if (advance_c) begin
        o_pattern <= (o_pattern == PAT_LAST) ? '0 : o_pattern + PAT_W'(1);
      end
      if (advance_c) begin
        pending <= 1'b0;
      end else if (btn_rise) begin
        pending <= 1'b1;
      end
      if (!i_auto || advance_c) begin
        frame_cnt <= '0;
      end else if (frame_start_c) begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
      if (frame_start_c) begin
        bar_pos  <= bar_next;
        bar_next <= bar_wrap_c;
      end
    end
  end

  // Stage 1: capture coordinates, range flag and bar numbers for both pixels.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      x1     <= '0;
      y1     <= '0;
      v1     <= 1'b0;
      in1    <= 1'b0;
      bar_e1 <= '0;
      bar_o1 <= '0;
    end else begin
      x1     <= i_x;
      y1     <= i_y;
      v1     <= i_valid;
      in1    <= (i_x < CW'(H_PAIRS)) && (i_y < CW'(V_ACTIVE));
      bar_e1 <= bar_index({i_x, 1'b0}, H_PAIRS);
      bar_o1 <= bar_index({i_x, 1'b1}, H_PAIRS);
    end
  end

  function automatic logic [COLOR_W-1:0] pix_color(
    input logic [PAT_W-1:0] pat,
    input logic [PXW-1:0]   px,
    input logic [CW-1:0]    y,
    input logic [2:0]       bar,
    input logic [PXW-1:0]   pos
  );
    logic [COLOR_W-1:0] c;
    logic [PXW:0]       px_w;
    logic [PXW:0]       pos_w;
    px_w  = (PXW + 1)'(px);
    pos_w = (PXW + 1)'(pos);
    c     = COLOR_BLACK;
    case (pat)
      PAT_WHITE:   c = COLOR_WHITE;
      PAT_BARS:    c = bar_color(bar);
      PAT_RAMP:    c = {3{px[9:2]}};
      PAT_CHECKER: c = (px[4] ^ y[4]) ? COLOR_WHITE : COLOR_BLACK;
      PAT_MOVING:  c = ((px_w >= pos_w) && (px_w <= pos_w + (PXW + 1)'(15))) ? COLOR_RED : COLOR_BLACK;
      PAT_BORDER:  c = ((px == '0) || (px == PX_LAST) || (y == '0) || (y == Y_LAST)) ?
                       COLOR_WHITE : COLOR_BLACK;
      default:     c = COLOR_BLACK;
    endcase
    return c;
  endfunction

  // Stage 2: colors update only for valid pairs and hold otherwise.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_color      <= '0;
      o_color_even <= '0;
      o_valid      <= 1'b0;
    end else begin
      o_valid <= v1;
      if (v1) begin
        o_color      <= in1 ? pix_color(o_pattern, {x1, 1'b0}, y1, bar_e1, bar_pos) : COLOR_BLACK;
        o_color_even <= in1 ? pix_color(o_pattern, {x1, 1'b1}, y1, bar_o1, bar_pos) : COLOR_BLACK;
      end
    end
  end

endmodule
